// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start(1), data MSB-first, stop(0).
// Line idles low; one IDLE (done) cycle separates consecutive frames.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             in_ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_clk_cnt;
  logic             r_out;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_n;
  logic [WIDTH-1:0] w_shift_n;
  logic [BW-1:0]    w_bit_n;
  logic [CW-1:0]    w_clk_n;
  logic             w_out_n;
  logic             w_busy_n;
  logic             w_done_n;
  logic             w_ready;
  logic             w_accept;
  logic             w_bit_end;
  logic             w_last_bit;

  assign w_ready    = (r_state == S_IDLE) && rst_n;
  assign w_accept   = in_valid && w_ready;
  assign w_bit_end  = (r_clk_cnt == CMAX);
  assign w_last_bit = (r_bit_cnt == BMAX);

  assign in_ready = w_ready;
  assign out      = r_out;
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_clk_cnt <= '0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_bit_cnt <= w_bit_n;
      r_clk_cnt <= w_clk_n;
      r_out     <= w_out_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
    end
  end

  // The MSB of r_shift is always the next data bit to put on the line.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bit_n   = r_bit_cnt;
    w_clk_n   = r_clk_cnt;
    w_out_n   = r_out;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_out_n  = 1'b0;
        w_busy_n = 1'b0;
        w_clk_n  = '0;
        w_bit_n  = '0;
        if (w_accept) begin
          w_state_n = S_START;
          w_shift_n = data_in;
          w_out_n   = 1'b1;
          w_busy_n  = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_n = S_DATA;
          w_clk_n   = '0;
          w_bit_n   = '0;
          w_out_n   = r_shift[WIDTH-1];
          w_shift_n = r_shift << 1;
        end else begin
          w_clk_n = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_clk_n = '0;
          if (w_last_bit) begin
            w_state_n = S_STOP;
            w_bit_n   = '0;
            w_out_n   = 1'b0;
          end else begin
            w_bit_n   = r_bit_cnt + 1'b1;
            w_out_n   = r_shift[WIDTH-1];
            w_shift_n = r_shift << 1;
          end
        end else begin
          w_clk_n = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        w_out_n = 1'b0;
        if (w_bit_end) begin
          w_state_n = S_IDLE;
          w_clk_n   = '0;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end else begin
          w_clk_n = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_out_n   = 1'b0;
        w_busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: expected line bits are queued when a word
// is offered and popped as the DUT drives each cycle.
module tb_serial_frame_tx;

  logic       clk;
  logic       rst1_n, v1, rdy1, out1, busy1, done1;
  logic [7:0] d1;
  logic       rst3_n, v3, rdy3, out3, busy3, done3;
  logic [7:0] d3;

  int   n_cmp;
  int   n_bad;
  logic q[$];
  logic exp_b;

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(v1), .data_in(d1),
    .in_ready(rdy1), .out(out1), .busy(busy1), .done(done1)
  );

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .in_valid(v3), .data_in(d3),
    .in_ready(rdy3), .out(out3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_frame(input logic [7:0] d, input int c);
    for (int k = 0; k < c; k++) q.push_back(1'b1);
    for (int b = 7; b >= 0; b--)
      for (int k = 0; k < c; k++) q.push_back(d[b]);
    for (int k = 0; k < c; k++) q.push_back(1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1_n = 1'b0; rst3_n = 1'b0;
    v1 = 1'b0; v3 = 1'b0; d1 = '0; d3 = '0;
    #12;
    n_cmp++;
    if ({out1, busy1, done1, rdy1} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset1: got %b want 0000", {out1, busy1, done1, rdy1});
    end
    n_cmp++;
    if ({out3, busy3, done3, rdy3} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset3: got %b want 0000", {out3, busy3, done3, rdy3});
    end
    rst1_n = 1'b1; rst3_n = 1'b1;
    #1;
    n_cmp++;
    if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b%b want 11", rdy1, rdy3);
    end
    tick();
  endtask

  task automatic test_basic();
    q.delete();
    v1 = 1'b1; d1 = 8'hA5;
    push_frame(8'hA5, 1);
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_b = q.pop_front();
      n_cmp++;
      if (out1 !== exp_b || busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_bit%0d: out=%b busy=%b done=%b want out=%b busy=1 done=0",
                 i, out1, busy1, done1, exp_b);
      end
      tick();
    end
    n_cmp++;
    if ({out1, done1, rdy1, busy1} !== 4'b0110) begin
      n_bad++;
      $display("FAIL basic_done: out/done/ready/busy=%b want 0110",
               {out1, done1, rdy1, busy1});
    end
    tick();
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_width: done=%b want 0", done1);
    end
  endtask

  task automatic test_stretch();
    q.delete();
    v3 = 1'b1; d3 = 8'h80;
    push_frame(8'h80, 3);
    tick();
    v3 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      exp_b = q.pop_front();
      n_cmp++;
      if (out3 !== exp_b || done3 !== 1'b0) begin
        n_bad++;
        $display("FAIL stretch_cyc%0d: out=%b done=%b want out=%b done=0",
                 i, out3, done3, exp_b);
      end
      tick();
    end
    n_cmp++;
    if (done3 !== 1'b1 || out3 !== 1'b0 || busy3 !== 1'b0) begin
      n_bad++;
      $display("FAIL stretch_done: done=%b out=%b busy=%b want 1 0 0",
               done3, out3, busy3);
    end
  endtask

  task automatic test_ignore_busy();
    q.delete();
    tick();
    v1 = 1'b1; d1 = 8'hFF;
    push_frame(8'hFF, 1);
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin v1 = 1'b1; d1 = 8'h00; end
      if (i == 5) v1 = 1'b0;
      exp_b = q.pop_front();
      n_cmp++;
      if (out1 !== exp_b || rdy1 !== 1'b0) begin
        n_bad++;
        $display("FAIL ignore_bit%0d: out=%b ready=%b want out=%b ready=0",
                 i, out1, rdy1, exp_b);
      end
      tick();
    end
    n_cmp++;
    if (done1 !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_done: done=%b want 1", done1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (out1 !== 1'b0 || busy1 !== 1'b0) begin
        n_bad++;
        $display("FAIL ignore_no_frame%0d: out=%b busy=%b want 0 0",
                 i, out1, busy1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    q.delete();
    n_done = 0;
    v1 = 1'b1; d1 = 8'h0F;
    push_frame(8'h0F, 1);
    q.push_back(1'b0);
    push_frame(8'hF0, 1);
    tick();
    d1 = 8'hF0;
    for (int i = 0; i < 21; i++) begin
      if (done1 === 1'b1) n_done++;
      if (i == 10) begin
        n_cmp++;
        if (done1 !== 1'b1 || rdy1 !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_gap: done=%b ready=%b want 1 1", done1, rdy1);
        end
      end
      if (i == 11) v1 = 1'b0;
      exp_b = q.pop_front();
      n_cmp++;
      if (out1 !== exp_b) begin
        n_bad++;
        $display("FAIL b2b_cyc%0d: out=%b want %b", i, out1, exp_b);
      end
      tick();
    end
    if (done1 === 1'b1) n_done++;
    tick();
    if (done1 === 1'b1) n_done++;
    n_cmp++;
    if (n_done != 2 || busy1 !== 1'b0 || out1 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: done_pulses=%0d busy=%b out=%b want 2 0 0",
               n_done, busy1, out1);
    end
  endtask

  task automatic test_async_reset();
    q.delete();
    tick();
    v1 = 1'b1; d1 = 8'hFF;
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (out1 !== 1'b1 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: out=%b busy=%b want 1 1", out1, busy1);
    end
    #2;
    rst1_n = 1'b0;
    #1;
    n_cmp++;
    if ({out1, rdy1, busy1, done1} !== 4'b0000) begin
      n_bad++;
      $display("FAIL arst_during: out/ready/busy/done=%b want 0000",
               {out1, rdy1, busy1, done1});
    end
    #2;
    rst1_n = 1'b1;
    #1;
    n_cmp++;
    if (rdy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_ready: ready=%b want 1", rdy1);
    end
    v1 = 1'b1; d1 = 8'h3C;
    push_frame(8'h3C, 1);
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_b = q.pop_front();
      n_cmp++;
      if (out1 !== exp_b || done1 !== 1'b0) begin
        n_bad++;
        $display("FAIL arst_frame%0d: out=%b done=%b want out=%b done=0",
                 i, out1, done1, exp_b);
      end
      tick();
    end
    n_cmp++;
    if (done1 !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_done: done=%b want 1", done1);
    end
  endtask

  task automatic test_data_hold();
    q.delete();
    tick();
    v1 = 1'b1; d1 = 8'hC3;
    push_frame(8'hC3, 1);
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d1 = 8'($urandom);
      exp_b = q.pop_front();
      n_cmp++;
      if (out1 !== exp_b) begin
        n_bad++;
        $display("FAIL hold_bit%0d: out=%b want %b", i, out1, exp_b);
      end
      tick();
    end
    n_cmp++;
    if (done1 !== 1'b1 || q.size() != 0) begin
      n_bad++;
      $display("FAIL hold_done: done=%b left=%0d want 1 0", done1, q.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_stretch();
    test_ignore_busy();
    test_back_to_back();
    test_async_reset();
    test_data_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
